// File: rtl/sonar_ranger.sv
// sonar_ranger: memory-mapped ultrasonic ranging peripheral.
// Fires trigger pulses on NUM_CH channels in round-robin order and times each
// echo pulse in clock cycles. Software starts single or continuous sweeps via
// CTRL and reads per-channel results plus valid/timeout flags.
//
// Register map (word offsets from BASE_ADDR):
//   0 CTRL    bit0 START (pulse, reads 0), bit1 CONT, bit2 ABORT (pulse, reads 0),
//             bits[8+NUM_CH-1:8] MASK
//   1 STATUS  bit0 busy, bits[8+NUM_CH-1:8] valid, bits[16+NUM_CH-1:16] timeout
//   2+ch      RESULT[ch], zero-extended
//
// Bus handshake: there is no valid/ready pair. A write is accepted on any rising
// edge where bus_hit && bus_we. A read has no strobe: bus_rdata always reflects
// the address presented before the previous rising edge (1-cycle latency).
module sonar_ranger #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 24,
  parameter int          TRIG_CYC    = 500,
  parameter int          GAP_CYC     = 50000,
  parameter int          TIMEOUT_CYC = 1500000,
  parameter logic [11:0] BASE_ADDR   = 12'hF00
) (
  input  logic              clock,
  input  logic              CPU_RESETN,
  input  logic [11:0]       bus_addr,
  input  logic              bus_we,
  input  logic [31:0]       bus_wdata,
  output logic              bus_hit,
  output logic [31:0]       bus_rdata,
  output logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] echo,
  output logic              busy
);

  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PMAX = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [12:0] LAST_ADDR = {1'b0, BASE_ADDR} + 13'(NUM_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP
  } state_t;

  // FSM state is kept as a named signal so checkers can bind to it directly.
  state_t             state;
  logic [CHW-1:0]     ch;
  logic [PW-1:0]      pcnt;
  logic [TW-1:0]      tcnt;
  logic [CNT_W-1:0]   wcnt;
  logic [NUM_CH-1:0]  mask;
  logic               cont;
  logic [NUM_CH-1:0]  valid;
  logic [NUM_CH-1:0]  tmo;
  logic [CNT_W-1:0]   result [NUM_CH];

  logic [NUM_CH-1:0]  echo_s1, echo_s2, echo_q;

  logic [11:0]        off;
  logic               wr_ctrl, start_req, abort_req;
  logic [NUM_CH-1:0]  wmask;
  logic               echo_rise, echo_fall;
  logic [CHW-1:0]     wlow, mlow, nxt;
  logic               mlow_ok, nxt_ok;
  logic [31:0]        rd_next;
  logic               unused_wdata;

  assign unused_wdata = ^{bus_wdata[31:8+NUM_CH], bus_wdata[7:3]};

  // Address decode and CTRL write strobes.
  always_comb begin
    off       = bus_addr - BASE_ADDR;
    bus_hit   = ({1'b0, bus_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, bus_addr} <= LAST_ADDR);
    wr_ctrl   = bus_hit && bus_we && (off == 12'd0);
    start_req = wr_ctrl && bus_wdata[0] && !bus_wdata[2];
    abort_req = wr_ctrl && bus_wdata[2];
    wmask     = bus_wdata[8 +: NUM_CH];
  end

  // Edge detection on the synchronised echo of the selected channel.
  always_comb begin
    echo_rise = echo_s2[ch] && !echo_q[ch];
    echo_fall = !echo_s2[ch] && echo_q[ch];
  end

  // Channel selection: lowest of the written mask, lowest of the live mask,
  // and next enabled channel above the current one.
  always_comb begin
    wlow    = '0;
    mlow    = '0;
    mlow_ok = 1'b0;
    nxt     = '0;
    nxt_ok  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (wmask[i]) wlow = CHW'(i);
      if (mask[i]) begin
        mlow    = CHW'(i);
        mlow_ok = 1'b1;
      end
      if (mask[i] && (i > int'(ch))) begin
        nxt    = CHW'(i);
        nxt_ok = 1'b1;
      end
    end
  end

  // Read mux; unmapped offsets return 0.
  always_comb begin
    rd_next = '0;
    if (bus_hit) begin
      if (off == 12'd0) begin
        rd_next[1]           = cont;
        rd_next[8 +: NUM_CH] = mask;
      end else if (off == 12'd1) begin
        rd_next[0]            = busy;
        rd_next[8 +: NUM_CH]  = valid;
        rd_next[16 +: NUM_CH] = tmo;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (off == 12'(i + 2)) rd_next = 32'(result[i]);
        end
      end
    end
  end

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clock) begin
    if (!CPU_RESETN) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_q  <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_q  <= echo_s2;
    end
  end

  // Registered read data.
  always_ff @(posedge clock) begin
    if (!CPU_RESETN) bus_rdata <= '0;
    else             bus_rdata <= rd_next;
  end

  // Control registers and the ranging sequencer.
  always_ff @(posedge clock) begin
    if (!CPU_RESETN) begin
      state <= S_IDLE;
      ch    <= '0;
      pcnt  <= '0;
      tcnt  <= '0;
      wcnt  <= '0;
      mask  <= '0;
      cont  <= 1'b0;
      valid <= '0;
      tmo   <= '0;
      trig  <= '0;
      busy  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        mask <= wmask;
        cont <= bus_wdata[1];
      end
      if (abort_req) begin
        // Current channel never stored anything, so its flags remain clear.
        state <= S_IDLE;
        trig  <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_req && (wmask != '0)) begin
              valid <= '0;
              tmo   <= '0;
              ch    <= wlow;
              trig  <= NUM_CH'(1) << wlow;
              pcnt  <= '0;
              busy  <= 1'b1;
              state <= S_TRIG;
            end
          end
          S_TRIG: begin
            if (pcnt == PW'(TRIG_CYC - 1)) begin
              trig  <= '0;
              tcnt  <= '0;
              state <= S_WAIT_RISE;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          S_WAIT_RISE: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
              result[ch] <= '1;
              tmo[ch]    <= 1'b1;
              valid[ch]  <= 1'b1;
              pcnt       <= '0;
              state      <= S_GAP;
            end else if (echo_rise) begin
              // The edge cycle is itself the first high cycle of the pulse.
              wcnt  <= CNT_W'(1);
              state <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            tcnt <= tcnt + 1'b1;
            if (echo_fall) begin
              result[ch] <= wcnt;
              valid[ch]  <= 1'b1;
              pcnt       <= '0;
              state      <= S_GAP;
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
              result[ch] <= '1;
              tmo[ch]    <= 1'b1;
              valid[ch]  <= 1'b1;
              pcnt       <= '0;
              state      <= S_GAP;
            end else if (wcnt != '1) begin
              wcnt <= wcnt + 1'b1;
            end
          end
          S_GAP: begin
            if (pcnt == PW'(GAP_CYC - 1)) begin
              pcnt <= '0;
              if (nxt_ok) begin
                ch    <= nxt;
                trig  <= NUM_CH'(1) << nxt;
                state <= S_TRIG;
              end else if (cont && mlow_ok) begin
                valid <= '0;
                tmo   <= '0;
                ch    <= mlow;
                trig  <= NUM_CH'(1) << mlow;
                state <= S_TRIG;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          default: begin
            trig  <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed plus randomized bench for sonar_ranger (2 channels, short timings).
// Echo pulses are driven from the main sequence; expected results come from a
// pulse-level model (echo width, or all-ones when the pulse outlives the timeout).
module tb_sonar_ranger;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int TRIG_CYC    = 4;
  localparam int GAP_CYC     = 8;
  localparam int TIMEOUT_CYC = 100;
  localparam logic [11:0] BASE   = 12'hF00;
  localparam logic [11:0] A_CTRL = BASE;
  localparam logic [11:0] A_STAT = BASE + 12'd1;
  localparam logic [11:0] A_RES0 = BASE + 12'd2;
  localparam logic [11:0] A_RES1 = BASE + 12'd3;

  logic              clock      = 1'b0;
  logic              CPU_RESETN = 1'b0;
  logic [11:0]       bus_addr   = '0;
  logic              bus_we     = 1'b0;
  logic [31:0]       bus_wdata  = '0;
  logic              bus_hit;
  logic [31:0]       bus_rdata;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] echo       = '0;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int trig1_count  = 0;

  logic [CNT_W-1:0] exp_q [$];

  sonar_ranger #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TRIG_CYC(TRIG_CYC), .GAP_CYC(GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .CPU_RESETN(CPU_RESETN), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_hit(bus_hit), .bus_rdata(bus_rdata),
    .trig(trig), .echo(echo), .busy(busy)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Trigger monitor: never two trig bits at once; count trig1 high cycles.
  always @(negedge clock) begin
    if (CPU_RESETN) begin
      check("trig_onehot", 32'($countones(trig) <= 1), 32'd1);
      if (trig[1]) trig1_count++;
    end
  end

  // Pulse-level reference: a pulse that ends inside the timeout window reads
  // back as its width in cycles (saturating); otherwise all ones.
  function automatic logic [CNT_W-1:0] model_result(input int dly, input int width, input bit rises);
    int maxv;
    maxv = (1 << CNT_W) - 1;
    if (!rises || (dly + width + 4 >= TIMEOUT_CYC)) return CNT_W'(maxv);
    if (width > maxv) return CNT_W'(maxv);
    return CNT_W'(width);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [11:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_we    = 1'b1;
    bus_wdata = data;
    @(negedge clock);
    bus_we    = 1'b0;
    bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [11:0] addr, output logic [31:0] data, output logic hit);
    bus_addr = addr;
    bus_we   = 1'b0;
    #1 hit = bus_hit;
    @(negedge clock);
    data = bus_rdata;
  endtask

  task automatic check_reg(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    bus_read(addr, d, h);
    check(tag, d, exp);
  endtask

  // Waits (bounded) for trig[ch] to rise, then measures its high time.
  task automatic wait_trig_pulse(input int ch);
    int n, w;
    n = 0;
    while (!trig[ch] && n < 200) begin tick(1); n++; end
    check($sformatf("trig%0d_rise", ch), 32'(trig[ch]), 32'd1);
    w = 0;
    while (trig[ch] && w < 50) begin tick(1); w++; end
    check($sformatf("trig%0d_width", ch), 32'(w), 32'(TRIG_CYC));
  endtask

  task automatic pulse(input int ch, input int dly, input int width);
    tick(dly);
    echo[ch] = 1'b1;
    tick(width);
    echo[ch] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin tick(1); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_result(input int ch);
    logic [CNT_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_reg($sformatf("result%0d", ch), A_RES0 + 12'(ch), 32'(e));
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    int          m, t1;
    int          dly [NUM_CH];
    int          wid [NUM_CH];

    // Reset block
    CPU_RESETN = 1'b0;
    tick(3);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    CPU_RESETN = 1'b1;
    tick(1);
    check_reg("rst_status", A_STAT, 32'h0);
    check_reg("rst_ctrl", A_CTRL, 32'h0);
    check_reg("rst_res0", A_RES0, 32'h0);

    // Two-channel sweep, echoes 20 and 35 cycles wide.
    exp_q.push_back(model_result(5, 20, 1'b1));
    exp_q.push_back(model_result(5, 35, 1'b1));
    bus_write(A_CTRL, 32'h0301);
    wait_trig_pulse(0);
    pulse(0, 5, 20);
    wait_trig_pulse(1);
    pulse(1, 5, 35);
    check("busy_in_gap", 32'(busy), 32'd1);
    wait_idle("sweep1_idle");
    check_reg("sweep1_res0", A_RES0, 32'(exp_q.pop_front()));
    check_reg("sweep1_res1", A_RES1, 32'(exp_q.pop_front()));
    check_reg("sweep1_status", A_STAT, 32'h0300);
    check_reg("sweep1_ctrl", A_CTRL, 32'h0300);

    // Writes to read-only offsets are ignored.
    bus_write(A_STAT, 32'hFFFF_FFFF);
    bus_write(A_RES0, 32'h0000_00AB);
    check_reg("ro_status", A_STAT, 32'h0300);
    check_reg("ro_res0", A_RES0, 32'd20);

    // Randomized sweeps over random masks.
    for (int it = 0; it < 4; it++) begin
      m = $urandom_range(1, 3);
      for (int c = 0; c < NUM_CH; c++) begin
        dly[c] = $urandom_range(1, 20);
        wid[c] = $urandom_range(1, 60);
      end
      bus_write(A_CTRL, (32'(m) << 8) | 32'h1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (m[c]) begin
          exp_q.push_back(model_result(dly[c], wid[c], 1'b1));
          wait_trig_pulse(c);
          pulse(c, dly[c], wid[c]);
        end
      end
      wait_idle("rand_idle");
      if (m[0]) check_reg("rand_res0", A_RES0, 32'(exp_q.pop_front()));
      if (m[1]) check_reg("rand_res1", A_RES1, 32'(exp_q.pop_front()));
      check_reg("rand_status", A_STAT, 32'(m) << 8);
    end

    // Echo never rises: timeout on channel 0, channel 1 never triggered.
    t1 = trig1_count;
    bus_write(A_CTRL, 32'h0101);
    wait_trig_pulse(0);
    wait_idle("tmo_idle");
    check_reg("tmo_res0", A_RES0, 32'(model_result(0, 0, 1'b0)));
    check_reg("tmo_status", A_STAT, 32'h0001_0100);
    check("tmo_no_trig1", 32'(trig1_count - t1), 32'd0);

    // Echo still high when the timeout expires.
    exp_q.push_back(model_result(5, 150, 1'b1));
    bus_write(A_CTRL, 32'h0101);
    wait_trig_pulse(0);
    pulse(0, 5, 150);
    wait_idle("long_idle");
    check_reg("long_res0", A_RES0, 32'(exp_q.pop_front()));
    check_reg("long_status", A_STAT, 32'h0001_0100);

    // Echo already high through TRIG: only a fresh 0->1 edge counts.
    echo[0] = 1'b1;
    tick(2);
    bus_write(A_CTRL, 32'h0101);
    wait_trig_pulse(0);
    tick(6);
    echo[0] = 1'b0;
    pulse(0, 10, 15);
    wait_idle("lvl_idle");
    check_reg("lvl_res0", A_RES0, 32'(model_result(10, 15, 1'b1)));
    check_reg("lvl_status", A_STAT, 32'h0100);

    // Continuous mode on channel 1, then CONT cleared mid-measurement.
    bus_write(A_CTRL, 32'h0203);
    for (int k = 0; k < 2; k++) begin
      wait_trig_pulse(1);
      pulse(1, 3, 10);
    end
    wait_trig_pulse(1);
    tick(3);
    echo[1] = 1'b1;
    tick(3);
    bus_write(A_CTRL, 32'h0200);
    tick(6);
    echo[1] = 1'b0;
    wait_idle("cont_idle");
    check_reg("cont_res1", A_RES1, 32'(model_result(3, 10, 1'b1)));
    check_reg("cont_status", A_STAT, 32'h0200);
    check_reg("cont_ctrl", A_CTRL, 32'h0200);
    t1 = trig1_count;
    tick(60);
    check("cont_stopped", 32'(trig1_count - t1), 32'd0);
    check("cont_busy", 32'(busy), 32'd0);

    // ABORT while measuring channel 1 after channel 0 completed.
    bus_write(A_CTRL, 32'h0301);
    wait_trig_pulse(0);
    pulse(0, 4, 12);
    wait_trig_pulse(1);
    tick(3);
    echo[1] = 1'b1;
    tick(4);
    bus_write(A_CTRL, 32'h0304);
    check("abort_trig", 32'(trig), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    echo[1] = 1'b0;
    check_reg("abort_status", A_STAT, 32'h0100);
    check_reg("abort_res0", A_RES0, 32'd12);

    // START with an empty mask is ignored.
    bus_write(A_CTRL, 32'h0001);
    tick(3);
    check("mask0_busy", 32'(busy), 32'd0);
    check_reg("mask0_status", A_STAT, 32'h0100);

    // ABORT and START in one write: ABORT wins.
    bus_write(A_CTRL, 32'h0305);
    tick(2);
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_start_trig", 32'(trig), 32'd0);

    // Reset during TRIG clears everything on the following edge.
    bus_write(A_CTRL, 32'h0301);
    check("rst_trig_rise", 32'(trig), 32'd1);
    tick(1);
    CPU_RESETN = 1'b0;
    tick(1);
    check("midrst_trig", 32'(trig), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    CPU_RESETN = 1'b1;
    check_reg("midrst_status", A_STAT, 32'h0);
    check_reg("midrst_res0", A_RES0, 32'h0);
    check_reg("midrst_ctrl", A_CTRL, 32'h0);
    bus_read(A_RES1, d, h);
    check("last_hit", 32'(h), 32'd1);
    check("midrst_res1", d, 32'h0);
    bus_read(BASE + 12'd4, d, h);
    check("past_end_hit", 32'(h), 32'd0);
    bus_read(BASE + 12'd7, d, h);
    check("off7_hit", 32'(h), 32'd0);
    check("off7_data", d, 32'h0);
    bus_read(BASE - 12'd1, d, h);
    check("below_base_hit", 32'(h), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
